// File: rtl/mem_axi_mm_initiator_pkg.sv
// mem_axi_mm_initiator_pkg: shared state encoding, AXI constants and pattern function
package mem_axi_mm_initiator_pkg;
  typedef logic [2:0] t_init_state;
  localparam t_init_state ST_IDLE  = 3'd0;
  localparam t_init_state ST_WR_AW = 3'd1;
  localparam t_init_state ST_WR_W  = 3'd2;
  localparam t_init_state ST_WR_B  = 3'd3;
  localparam t_init_state ST_RD_AR = 3'd4;
  localparam t_init_state ST_RD_R  = 3'd5;
  localparam t_init_state ST_DONE  = 3'd6;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  function automatic logic [31:0] f_pattern(input logic [31:0] seed, input logic [31:0] k);
    return seed + k;
  endfunction
endpackage

// File: rtl/mem_axi_mm_initiator_if.sv
// mem_axi_mm_initiator_if: AXI-MM bus between the initiator and the memory responder
interface mem_axi_mm_initiator_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 9
) ();
  logic                    awvalid, awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic [ID_WIDTH-1:0]     awid;
  logic                    wvalid, wready, wlast;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    bvalid, bready;
  logic [1:0]              bresp;
  logic                    arvalid, arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic [ID_WIDTH-1:0]     arid;
  logic                    rvalid, rready, rlast;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  modport master (
    output awvalid, awaddr, awlen, awsize, awburst, awid, wvalid, wdata, wstrb, wlast,
           bready, arvalid, araddr, arlen, arsize, arburst, arid, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast
  );
  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst, awid, wvalid, wdata, wstrb, wlast,
           bready, arvalid, araddr, arlen, arsize, arburst, arid, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast
  );
endinterface

// File: rtl/mem_axi_mm_initiator_chk.sv
// mem_axi_mm_initiator_chk: B/R response checker with saturating error count and first-error capture
module mem_axi_mm_initiator_chk
  import mem_axi_mm_initiator_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 512
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  b_ev,
  input  logic [1:0]            bresp,
  input  logic                  r_ev,
  input  logic [1:0]            rresp,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  rlast,
  input  logic [DATA_WIDTH-1:0] exp_data,
  input  logic                  last_beat,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);
  logic err;
  logic [ADDR_WIDTH-1:0] addr;
  // a beat failing several checks still counts once
  always_comb begin
    err = b_ev ? bresp != AXI_RESP_OKAY
               : r_ev & (rresp != AXI_RESP_OKAY | rdata != exp_data | rlast != last_beat);
    addr = b_ev ? b_addr : r_addr;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (clr) begin
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (err) begin
      if (err_count == '0) first_err_addr <= addr;
      if (err_count != '1) err_count <= err_count + 16'd1;
    end
endmodule

// File: rtl/mem_axi_mm_initiator.sv
// mem_axi_mm_initiator: pattern write/read-back memory self-test over INCR bursts, one transaction at a time
module mem_axi_mm_initiator
  import mem_axi_mm_initiator_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 9,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [15:0]           num_bursts,
  input  logic [31:0]           seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  mem_axi_mm_initiator_if.master axi
);
  localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES  = ADDR_WIDTH'(DATA_WIDTH/8);
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN*DATA_WIDTH/8);
  localparam logic [7:0] LEN_M1 = 8'(BURST_LEN-1);
  localparam logic [2:0] SIZE   = 3'($clog2(DATA_WIDTH/8));
  t_init_state st;
  logic [ADDR_WIDTH-1:0] base_q, baddr;
  logic [15:0] nb_q, bcnt;
  logic [31:0] seed_q, k;
  logic [7:0] beat;
  logic aw_v, w_v, ar_v, go, last_beat, last_burst;
  logic [DATA_WIDTH-1:0] pat;
  always_comb begin
    go         = start & (st == ST_IDLE | st == ST_DONE);
    last_beat  = beat == LEN_M1;
    last_burst = bcnt == nb_q - 16'd1;
    busy       = !(st == ST_IDLE | st == ST_DONE);
    done       = st == ST_DONE;
    pass       = done & err_count == '0;
    pat        = {(DATA_WIDTH/32){f_pattern(seed_q, k)}};
  end
  assign axi.awvalid = aw_v;
  assign axi.awaddr  = baddr;
  assign axi.awlen   = aw_v ? LEN_M1 : '0;
  assign axi.awsize  = aw_v ? SIZE : '0;
  assign axi.awburst = aw_v ? AXI_BURST_INCR : '0;
  assign axi.awid    = ID_WIDTH'(0);
  assign axi.wvalid  = w_v;
  assign axi.wdata   = pat;
  assign axi.wstrb   = '1;
  assign axi.wlast   = w_v & last_beat;
  assign axi.bready  = st == ST_WR_B;
  assign axi.arvalid = ar_v;
  assign axi.araddr  = baddr;
  assign axi.arlen   = ar_v ? LEN_M1 : '0;
  assign axi.arsize  = ar_v ? SIZE : '0;
  assign axi.arburst = ar_v ? AXI_BURST_INCR : '0;
  assign axi.arid    = ID_WIDTH'(0);
  assign axi.rready  = st == ST_RD_R;
  // k is the global beat index; it restarts at 0 for the read-back pass
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st <= ST_IDLE;
      {base_q, baddr, nb_q, bcnt, seed_q, k, beat} <= '0;
      {aw_v, w_v, ar_v} <= '0;
    end else if (go) begin
      base_q <= base_addr;
      baddr  <= base_addr;
      nb_q   <= num_bursts;
      seed_q <= seed;
      bcnt   <= '0;
      beat   <= '0;
      k      <= '0;
      aw_v   <= num_bursts != '0;
      st     <= num_bursts == '0 ? ST_DONE : ST_WR_AW;
    end else
      case (st)
        ST_WR_AW: if (axi.awready) begin
          aw_v <= 1'b0;
          w_v  <= 1'b1;
          st   <= ST_WR_W;
        end
        ST_WR_W: if (axi.wready) begin
          k    <= k + 32'd1;
          beat <= last_beat ? '0 : beat + 8'd1;
          if (last_beat) begin
            w_v <= 1'b0;
            st  <= ST_WR_B;
          end
        end
        ST_WR_B: if (axi.bvalid) begin
          bcnt  <= last_burst ? '0 : bcnt + 16'd1;
          baddr <= last_burst ? base_q : baddr + BURST_BYTES;
          k     <= last_burst ? '0 : k;
          aw_v  <= !last_burst;
          ar_v  <= last_burst;
          st    <= last_burst ? ST_RD_AR : ST_WR_AW;
        end
        ST_RD_AR: if (axi.arready) begin
          ar_v <= 1'b0;
          st   <= ST_RD_R;
        end
        ST_RD_R: if (axi.rvalid) begin
          k    <= k + 32'd1;
          beat <= last_beat ? '0 : beat + 8'd1;
          if (last_beat) begin
            bcnt  <= bcnt + 16'd1;
            baddr <= baddr + BURST_BYTES;
            ar_v  <= !last_burst;
            st    <= last_burst ? ST_DONE : ST_RD_AR;
          end
        end
        default: ;
      endcase
  mem_axi_mm_initiator_chk #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_chk (
    .clk            (clk),
    .reset          (reset),
    .clr            (go),
    .b_ev           (axi.bvalid & axi.bready),
    .bresp          (axi.bresp),
    .r_ev           (axi.rvalid & axi.rready),
    .rresp          (axi.rresp),
    .rdata          (axi.rdata),
    .rlast          (axi.rlast),
    .exp_data       (pat),
    .last_beat      (last_beat),
    .b_addr         (baddr),
    .r_addr         (baddr + ADDR_WIDTH'(beat) * BEAT_BYTES),
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );
endmodule
